// File: rtl/add_result_stage.sv
// Adder result stage: overflow/saturation, Z/V/N flags, 2-entry skid buffer.
// Optional macro ADD_SAT_EN enables signed saturation of the result.
module add_result_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] add_a,
  input  logic [15:0] add_b,
  input  logic [15:0] add_sum,
  input  logic        add_cout,
  input  logic        flag_we,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic        out_cout,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_n
);

  typedef struct packed {
    logic [15:0] res;
    logic        cout;
    logic        v;
    logic        z;
    logic        n;
    logic        we;
  } beat_t;

  beat_t       beat_in;
  beat_t       main_q, main_d;
  beat_t       skid_q, skid_d;
  logic        main_v_q, main_v_d;
  logic        skid_v_q, skid_v_d;
  logic [2:0]  flags_q, flags_d;
  logic        in_xfer;
  logic        out_xfer;

  // Per-beat overflow, final result and Z/N derived from that result
  always_comb begin
    beat_in      = '0;
    beat_in.cout = add_cout;
    beat_in.we   = flag_we;
    beat_in.v    = (add_a[15] == add_b[15]) &&
                   (add_sum[15] != add_a[15]);
`ifdef ADD_SAT_EN
    if (beat_in.v)
      beat_in.res = add_a[15] ? 16'h8000 : 16'h7FFF;
    else
      beat_in.res = add_sum;
`else
    beat_in.res  = add_sum;
`endif
    beat_in.z    = (beat_in.res == 16'h0000);
    beat_in.n    = beat_in.res[15];
  end

  assign in_ready = !skid_v_q;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_v_q && out_ready;

  // Next-state for main/skid storage and flag register
  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    flags_d  = flags_q;
    if (out_xfer && main_q.we)
      flags_d = {main_q.z, main_q.v, main_q.n};
    if (out_xfer || !main_v_q) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else if (in_xfer) begin
        main_d   = beat_in;
        main_v_d = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_d   = beat_in;
      skid_v_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q   <= '0;
      main_v_q <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      flags_q  <= '0;
    end else begin
      main_q   <= main_d;
      main_v_q <= main_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
      flags_q  <= flags_d;
    end
  end

  assign out_valid  = main_v_q;
  assign out_result = main_q.res;
  assign out_cout   = main_q.cout;
  assign flag_z     = flags_q[2];
  assign flag_v     = flags_q[1];
  assign flag_n     = flags_q[0];

endmodule

// File: doc/add_result_stage.md
ADD_RESULT_STAGE -- requirements
Module: add_result_stage

Interface
REQ-001 Parameters: none; fixed 16-bit datapath.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  upstream beat present: adder operands and adder result valid this cycle.
REQ-005 in_ready  output  1  stage can accept a beat this cycle.
REQ-006 add_a  input  16  operand A as applied to the 16-bit CLA.
REQ-007 add_b  input  16  operand B as applied to the CLA (already inverted for SUB).
REQ-008 add_sum  input  16  CLA Sum for add_a/add_b.
REQ-009 add_cout  input  1  CLA Cout.
REQ-010 flag_we  input  1  beat updates the flag register when delivered.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts the beat this cycle.
REQ-013 out_result  output  16  final (optionally saturated) result.
REQ-014 out_cout  output  1  registered copy of add_cout for the beat.
REQ-015 flag_z, flag_v, flag_n  output  1 each  architectural flag register.

Function
REQ-016 Input transfer: in_valid && in_ready in the same cycle; output transfer: out_valid && out_ready.
REQ-017 Overflow per beat: v = (add_a[15] == add_b[15]) && (add_sum[15] != add_a[15]).
REQ-018 Result per beat: v=1 && add_a[15]=0 -> 16'h7FFF; v=1 && add_a[15]=1 -> 16'h8000; otherwise add_sum (when ADD_SAT_EN defined).
REQ-019 Per-beat z = (result == 16'h0000), n = result[15], computed from the final result.
REQ-020 Storage: main register (drives outputs) plus one skid register; each holds result, cout, v, z, n, flag_we, valid bit.
REQ-021 in_ready = !skid_valid, registered; no combinational path from out_ready to in_ready.
REQ-022 Accepted beat goes to main when main empty or main transfers out this cycle, else to skid.
REQ-023 When main transfers and skid valid, skid moves to main next cycle; a simultaneous input transfer is impossible (in_ready=0).
REQ-024 Latency: accepted beat appears on out_* the next cycle when stage empty; ordering strictly FIFO.
REQ-025 Throughput: one beat per cycle sustained while out_ready=1.
REQ-026 out_valid held and out_result/out_cout stable while out_valid && !out_ready.
REQ-027 Flags: on output transfer of a beat with flag_we=1, {flag_z,flag_v,flag_n} <= that beat's {z,v,n} the next edge; else hold.
REQ-028 Beats with flag_we=0 never alter flags; flag_v reports overflow even when result saturated.
REQ-029 Full condition: main and skid valid -> in_ready=0; upstream must hold its beat.

Reset
REQ-030 rst_n=0 at a rising edge: main and skid valid cleared, in_ready=1, out_valid=0, out_result=16'h0000, out_cout=0, flags=0.
REQ-031 Reset mid-operation discards buffered beats without flag update; reset has priority over all transfers.
REQ-032 First transfer possible in the cycle after rst_n returns high.

Configuration
REQ-033 Macro ADD_SAT_EN: defined -> REQ-018 saturation; undefined -> result = add_sum always (wrap), v/z/n still per REQ-017/019, z/n from wrapped sum.

Verification
REQ-034 ADD_SAT_EN, a=16'h7FFF, b=16'h0001, sum=16'h8000, flag_we=1, out_ready=1 -> next cycle out_result=16'h7FFF; after transfer Z=0,V=1,N=0.
REQ-035 ADD_SAT_EN, a=16'h8000, b=16'hFFFF, sum=16'h7FFF, cout=1 -> out_result=16'h8000, out_cout=1, V=1,N=1; without macro out_result=16'h7FFF, N=0.
REQ-036 a=16'h0005, b=16'hFFFA, sum=16'hFFFF then a=16'h0005, b=16'hFFFB, sum=16'h0000, cout=1 -> results FFFF then 0000; flags N=1 then Z=1.
REQ-037 out_ready=0, three beats offered -> first two accepted, in_ready=0 on third; raise out_ready -> all three delivered in order, no loss/duplication.
REQ-038 Beat with flag_we=0 and sum=16'h0000 after flags Z=0,N=1 -> flags unchanged.
REQ-039 Two beats buffered, rst_n=0 one cycle -> out_valid=0, in_ready=1, flags=0, nothing delivered.
